// File: rtl/rf_tx_pkg.sv
// Shared types and constants for the RF transmit sequencer: FSM state encoding,
// frame-mode encoding and a helper that sizes counters from their maximum value.
package rf_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PWR_ON  = 3'd1,
        ST_ISO_OFF = 3'd2,
        ST_SHIFT   = 3'd3,
        ST_DONE    = 3'd4,
        ST_PWR_OFF = 3'd5
    } state_e;

    localparam logic MODE_FULL  = 1'b0;
    localparam logic MODE_SHORT = 1'b1;
    localparam int   SHORT_LEN  = 8;

    // Number of bits needed to hold any value in 0..max_value (at least 1).
    function automatic int cnt_width(input int max_value);
        int w;
        w = 1;
        while ((64'd1 << w) <= 64'(max_value)) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/rf_tx_serializer.sv
// MSB-first serializer: holds each bit for BIT_DIV clocks and flags the final
// clock of the last bit period so the sequencer can leave SHIFT on time.
module rf_tx_serializer
    import rf_tx_pkg::*;
#(
    parameter  int DATA_WIDTH = 32,
    parameter  int BIT_DIV    = 4,
    localparam int LEN_W      = cnt_width(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  load_i,
    input  logic [DATA_WIDTH-1:0] payload_i,
    input  logic [LEN_W-1:0]      length_i,
    output logic                  tx_serial_o,
    output logic                  tx_valid_o,
    output logic                  last_bit_o
);

    localparam int DIV_W = cnt_width(BIT_DIV);

    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [LEN_W-1:0]      bit_q, bit_d;
    logic [LEN_W-1:0]      len_q, len_d;
    logic [DIV_W-1:0]      div_q, div_d;
    logic                  valid_q, valid_d;
    logic                  bit_end;
    logic                  last;

    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path can infer a latch.
        shift_d = shift_q;
        bit_d   = bit_q;
        len_d   = len_q;
        div_d   = div_q;
        valid_d = valid_q;
        bit_end = valid_q && (div_q == DIV_W'(BIT_DIV - 1));
        last    = bit_end && (bit_q == len_q - LEN_W'(1));

        if (load_i) begin
            // Left-align short frames so the MSB of the frame sits at the top.
            shift_d = payload_i << (LEN_W'(DATA_WIDTH) - length_i);
            bit_d   = '0;
            div_d   = '0;
            len_d   = length_i;
            valid_d = 1'b1;
        end else if (bit_end) begin
            div_d = '0;
            if (last) begin
                valid_d = 1'b0;
            end else begin
                bit_d   = bit_q + LEN_W'(1);
                shift_d = shift_q << 1;
            end
        end else if (valid_q) begin
            div_d = div_q + DIV_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            shift_q <= '0;
            bit_q   <= '0;
            len_q   <= '0;
            div_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            shift_q <= shift_d;
            bit_q   <= bit_d;
            len_q   <= len_d;
            div_q   <= div_d;
            valid_q <= valid_d;
        end
    end

    assign tx_serial_o = valid_q & shift_q[DATA_WIDTH-1];
    assign tx_valid_o  = valid_q;
    assign last_bit_o  = last;

endmodule

// File: rtl/rf_tx_sequencer.sv
// RF transmit sequencer: powers up the transmitter, releases isolation, sends one
// frame through the serializer, pulses rf_tx_done and optionally powers back down.
module rf_tx_sequencer
    import rf_tx_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int PWRUP_CYCLES = 16,
    parameter int ISO_CYCLES   = 2,
    parameter int BIT_DIV      = 4
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  rf_tx_start,
    input  logic                  rf_tx_mode,
    input  logic                  rf_power_domain,
    input  logic [DATA_WIDTH-1:0] rf_tx_data,
    output logic                  rf_tx_done,
    output logic                  tx_pwr_en,
    output logic                  tx_iso_n,
    output logic                  tx_serial,
    output logic                  tx_valid,
    output logic                  busy
);

    localparam int LEN_W  = cnt_width(DATA_WIDTH);
    localparam int PH_MAX = (PWRUP_CYCLES > ISO_CYCLES) ? PWRUP_CYCLES : ISO_CYCLES;
    localparam int PH_W   = cnt_width(PH_MAX);

    state_e                state_q, state_d;
    logic                  start_q;
    logic                  pending_q, pending_d;
    logic [PH_W-1:0]       phase_q, phase_d;
    logic                  pwr_en_q, pwr_en_d;
    logic                  iso_n_q, iso_n_d;
    logic [DATA_WIDTH-1:0] data_sh_q, data_sh_d;
    logic                  mode_sh_q, mode_sh_d;

    logic                  start_edge;
    logic                  req;
    logic                  pwr_off_idle;
    logic                  launch;
    logic                  ser_load;
    logic                  ser_short;
    logic [DATA_WIDTH-1:0] ser_payload;
    logic [LEN_W-1:0]      ser_len;
    logic                  last_bit;

    assign start_edge   = rf_tx_start & ~start_q;
    assign req          = start_edge | pending_q;
    // Powering down an idle, powered transmitter wins over a launch in the same cycle.
    assign pwr_off_idle = (state_q == ST_IDLE) && pwr_en_q && !rf_power_domain;
    assign launch       = (state_q == ST_IDLE) && req && !pwr_off_idle;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (pwr_off_idle)  state_d = ST_PWR_OFF;
                else if (req)      state_d = pwr_en_q ? ST_SHIFT : ST_PWR_ON;
            end
            ST_PWR_ON:  if (phase_q == PH_W'(PWRUP_CYCLES - 1)) state_d = ST_ISO_OFF;
            ST_ISO_OFF: if (phase_q == PH_W'(ISO_CYCLES - 1))   state_d = ST_SHIFT;
            ST_SHIFT:   if (last_bit)                           state_d = ST_DONE;
            ST_DONE:    state_d = rf_power_domain ? ST_IDLE : ST_PWR_OFF;
            ST_PWR_OFF: if (phase_q == PH_W'(ISO_CYCLES - 1))   state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        rf_tx_done = (state_q == ST_DONE);
        busy       = (state_q != ST_IDLE);
        tx_pwr_en  = pwr_en_q;
        tx_iso_n   = iso_n_q;
    end

    always_comb begin
        pending_d = pending_q;
        phase_d   = '0;
        pwr_en_d  = pwr_en_q;
        iso_n_d   = iso_n_q;
        data_sh_d = data_sh_q;
        mode_sh_d = mode_sh_q;

        // One-deep request memory: later edges while pending are simply absorbed.
        if (launch)          pending_d = 1'b0;
        else if (start_edge) pending_d = 1'b1;

        if (launch) begin
            data_sh_d = rf_tx_data;
            mode_sh_d = rf_tx_mode;
        end

        if (state_d == state_q &&
            (state_q == ST_PWR_ON || state_q == ST_ISO_OFF || state_q == ST_PWR_OFF)) begin
            phase_d = phase_q + PH_W'(1);
        end

        if (state_d == ST_PWR_ON && state_q != ST_PWR_ON)       pwr_en_d = 1'b1;
        else if (state_q == ST_PWR_OFF && state_d == ST_IDLE)   pwr_en_d = 1'b0;

        if (state_q == ST_ISO_OFF && state_d == ST_SHIFT)       iso_n_d = 1'b1;
        else if (state_d == ST_PWR_OFF && state_q != ST_PWR_OFF) iso_n_d = 1'b0;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            start_q   <= 1'b1;
            pending_q <= 1'b0;
            phase_q   <= '0;
            pwr_en_q  <= 1'b0;
            iso_n_q   <= 1'b0;
            data_sh_q <= '0;
            mode_sh_q <= MODE_FULL;
        end else begin
            start_q   <= rf_tx_start;
            pending_q <= pending_d;
            phase_q   <= phase_d;
            pwr_en_q  <= pwr_en_d;
            iso_n_q   <= iso_n_d;
            data_sh_q <= data_sh_d;
            mode_sh_q <= mode_sh_d;
        end
    end

    // A powered launch loads straight from the inputs; otherwise from the shadow copy.
    assign ser_load    = (state_d == ST_SHIFT) && (state_q != ST_SHIFT);
    assign ser_short   = launch ? rf_tx_mode : mode_sh_q;
    assign ser_payload = launch ? rf_tx_data : data_sh_q;
    assign ser_len     = (ser_short == MODE_SHORT) ? LEN_W'(SHORT_LEN) : LEN_W'(DATA_WIDTH);

    rf_tx_serializer #(
        .DATA_WIDTH (DATA_WIDTH),
        .BIT_DIV    (BIT_DIV)
    ) u_serializer (
        .clk         (clk),
        .resetn      (resetn),
        .load_i      (ser_load),
        .payload_i   (ser_payload),
        .length_i    (ser_len),
        .tx_serial_o (tx_serial),
        .tx_valid_o  (tx_valid),
        .last_bit_o  (last_bit)
    );

endmodule

// File: tb/tb_rf_tx_sequencer.sv
// Self-checking bench for rf_tx_sequencer: each frame's expected waveform is
// derived from the timing rules (power-up, isolation, bit periods) by arithmetic.
module tb_rf_tx_sequencer;

    localparam int DW = 32;
    localparam int P  = 16;
    localparam int I  = 2;
    localparam int B  = 4;

    logic          clk = 1'b0;
    logic          resetn = 1'b1;
    logic          rf_tx_start = 1'b0;
    logic          rf_tx_mode = 1'b0;
    logic          rf_power_domain = 1'b0;
    logic [DW-1:0] rf_tx_data = '0;
    logic          rf_tx_done, tx_pwr_en, tx_iso_n, tx_serial, tx_valid, busy;
    logic [5:0]    obs;

    int checks = 0;
    int errors = 0;
    bit model_powered = 1'b0;

    rf_tx_sequencer #(
        .DATA_WIDTH   (DW),
        .PWRUP_CYCLES (P),
        .ISO_CYCLES   (I),
        .BIT_DIV      (B)
    ) dut (
        .clk             (clk),
        .resetn          (resetn),
        .rf_tx_start     (rf_tx_start),
        .rf_tx_mode      (rf_tx_mode),
        .rf_power_domain (rf_power_domain),
        .rf_tx_data      (rf_tx_data),
        .rf_tx_done      (rf_tx_done),
        .tx_pwr_en       (tx_pwr_en),
        .tx_iso_n        (tx_iso_n),
        .tx_serial       (tx_serial),
        .tx_valid        (tx_valid),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    // Bit order: busy, pwr_en, iso_n, valid, serial, done.
    assign obs = {busy, tx_pwr_en, tx_iso_n, tx_valid, tx_serial, rf_tx_done};

    // Follows one frame from the cycle after its launch (k=1) until the sequencer
    // is back in IDLE. The launch cycle (k=0) is the caller's current cycle.
    task automatic check_frame(input string tag, input logic [DW-1:0] data, input bit mode,
                               input bit pd, input int abort_k, input int repulse_k,
                               input logic [DW-1:0] new_data, input bit new_mode);
        int f, len, dn, last;
        logic [5:0] exp, mask;
        f    = model_powered ? 1 : 1 + P + I;
        len  = mode ? 8 : DW;
        dn   = f + len * B;
        last = pd ? dn + 1 : dn + 1 + I;
        for (int k = 1; k <= last; k++) begin
            @(posedge clk);
            @(negedge clk);
            exp  = '0;
            mask = 6'b111111;
            exp[5] = (k < last);
            exp[4] = !(!pd && k == last);
            if (k >= f)              exp[3] = (k <= dn) ? 1'b1 : pd;
            else if (k > P)          mask[3] = 1'b0;
            exp[2] = (k >= f) && (k < dn);
            exp[1] = exp[2] ? data[len - 1 - (k - f) / B] : 1'b0;
            exp[0] = (k == dn);
            checks++;
            if ((obs & mask) !== (exp & mask)) begin
                errors++;
                $display("FAIL %s k=%0d got=%b expected=%b mask=%b", tag, k, obs, exp, mask);
            end
            if (k == abort_k) return;
            if (k == 2) rf_tx_start = 1'b0;
            if (k == 3) begin
                rf_tx_data = $urandom;
                rf_tx_mode = 1'($urandom_range(0, 1));
            end
            if (repulse_k > 3 && k == repulse_k) begin
                rf_tx_start = 1'b1;
                rf_tx_data  = new_data;
                rf_tx_mode  = new_mode;
            end
            if (repulse_k > 3 && k == repulse_k + 1) rf_tx_start = 1'b0;
        end
        model_powered = pd;
    endtask

    // Raises a start edge from IDLE; a powered idle with power_domain dropping to 0
    // first runs the power-down, then the held request launches unpowered.
    task automatic launch_frame(input string tag, input logic [DW-1:0] data, input bit mode,
                                input bit pd);
        logic [5:0] exp;
        @(negedge clk);
        rf_tx_data      = data;
        rf_tx_mode      = mode;
        rf_power_domain = pd;
        rf_tx_start     = 1'b1;
        if (model_powered && !pd) begin
            for (int k = 1; k <= I + 1; k++) begin
                @(posedge clk);
                @(negedge clk);
                exp = {1'(k <= I), 1'(k <= I), 4'b0000};
                checks++;
                if (obs !== exp) begin
                    errors++;
                    $display("FAIL %s_pwr_off k=%0d got=%b expected=%b", tag, k, obs, exp);
                end
                if (k == 1) rf_tx_start = 1'b0;
            end
            model_powered = 1'b0;
        end
        check_frame(tag, data, mode, pd, 0, 0, '0, 1'b0);
    endtask

    task automatic test_reset();
        rf_tx_start = 1'b1;
        #1 resetn = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (obs !== 6'b0) begin
                errors++;
                $display("FAIL reset_held c=%0d got=%b expected=000000", c, obs);
            end
        end
        resetn = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            checks++;
            if (obs !== 6'b0) begin
                errors++;
                $display("FAIL reset_release_start_high c=%0d got=%b expected=000000", c, obs);
            end
            if (c == 3) rf_tx_start = 1'b0;
        end
        model_powered = 1'b0;
    endtask

    task automatic test_default_frame();
        launch_frame("default_full", 32'hA5C3_0F81, 1'b0, 1'b0);
    endtask

    task automatic test_short_powered();
        launch_frame("short_first", 32'h0000_00B2, 1'b1, 1'b1);
        launch_frame("short_powered", 32'h0000_00B2, 1'b1, 1'b1);
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] d1;
        d1 = $urandom;
        @(negedge clk);
        rf_tx_data      = d1;
        rf_tx_mode      = 1'b0;
        rf_power_domain = 1'b1;
        rf_tx_start     = 1'b1;
        check_frame("b2b_first", d1, 1'b0, 1'b1, 0, 1 + 5 * B + 1, 32'h1234_5678, 1'b0);
        check_frame("b2b_second", 32'h1234_5678, 1'b0, 1'b1, 0, 0, '0, 1'b0);
    endtask

    task automatic test_power_domain_change();
        launch_frame("pd_change", $urandom, 1'b1, 1'b0);
    endtask

    task automatic test_reset_mid_shift();
        @(negedge clk);
        rf_tx_data      = $urandom;
        rf_tx_mode      = 1'b0;
        rf_power_domain = 1'b0;
        rf_tx_start     = 1'b1;
        check_frame("mid_shift", rf_tx_data, 1'b0, 1'b0, 1 + P + I + 10 * B, 0, '0, 1'b0);
        resetn = 1'b0;
        #1;
        checks++;
        if (obs !== 6'b0) begin
            errors++;
            $display("FAIL reset_async got=%b expected=000000", obs);
        end
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++;
            if (obs !== 6'b0) begin
                errors++;
                $display("FAIL reset_mid_shift_hold c=%0d got=%b expected=000000", c, obs);
            end
        end
        resetn = 1'b1;
        model_powered = 1'b0;
        launch_frame("after_reset", $urandom, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 6; n++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            launch_frame("random", $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        test_reset();
        test_default_frame();
        test_short_powered();
        test_back_to_back();
        test_power_domain_change();
        test_reset_mid_shift();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
